// File: rtl/led_map_pkg.sv
// Shared geometry defaults and the glyph ROM for the LED matrix scanner.
// Pure constants and a combinational helper; no state, no latency.
// No flow control: consumers read the ROM directly.
package led_map_pkg;

  localparam int DEF_ROWS     = 7;
  localparam int DEF_COLS     = 5;
  localparam int DEF_MAP_BITS = 3;
  localparam int DEF_NUM_MAPS = 8;

  // Positive-logic patterns, bit r*COLS+c is row r / column c, 1 = lit.
  // Each entry is written row 6 first down to row 0 so row 0 lands in bits 4:0.
  localparam logic [DEF_ROWS*DEF_COLS-1:0] MAP_ROM [DEF_NUM_MAPS] = '{
    {5'b01110, 5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b01110},
    {5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01100, 5'b00100},
    {5'b11111, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110},
    {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b00010, 5'b11111},
    {5'b00010, 5'b00010, 5'b11111, 5'b10010, 5'b01010, 5'b00110, 5'b00010},
    {5'b01110, 5'b10001, 5'b00001, 5'b00001, 5'b11110, 5'b10000, 5'b11111},
    {5'b01110, 5'b10001, 5'b10001, 5'b11110, 5'b10000, 5'b01000, 5'b00110},
    {5'b01000, 5'b01000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b11111}
  };

  // Extract one row of one map; out-of-range indices read as an unlit row.
  function automatic logic [DEF_COLS-1:0] rom_row(input int m, input int r);
    logic [DEF_COLS-1:0]          row;
    logic [DEF_ROWS*DEF_COLS-1:0] pat;
    row = '0;
    pat = '0;
    if (m >= 0 && m < DEF_NUM_MAPS && r >= 0 && r < DEF_ROWS) begin
      pat = MAP_ROM[m[DEF_MAP_BITS-1:0]];
      for (int c = 0; c < DEF_COLS; c++) begin
        row[c] = pat[r*DEF_COLS + c];
      end
    end
    return row;
  endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Control and pin bundle between the map-selecting logic and the scanner.
// Wires only; timing is set by the scanner.
// No backpressure: load is a fire-and-forget strobe, errors come back as sel_err.
interface led_matrix_scan_if
  import led_map_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int MAP_BITS = DEF_MAP_BITS
);

  logic                en;
  logic [MAP_BITS-1:0] map_sel;
  logic                load;
  logic [ROWS-1:0]     row_n;
  logic [COLS-1:0]     col_n;
  logic [MAP_BITS-1:0] active_map;
  logic                frame_done;
  logic                sel_err;

  modport master (
    output en, map_sel, load,
    input  row_n, col_n, active_map, frame_done, sel_err
  );

  modport slave (
    input  en, map_sel, load,
    output row_n, col_n, active_map, frame_done, sel_err
  );

endinterface

// File: rtl/map_rom.sv
// Combinational (map, row) -> column pattern lookup into the package ROM.
// Zero latency.
// No flow control.
module map_rom
  import led_map_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int MAP_BITS = DEF_MAP_BITS,
  parameter int RW       = 3
) (
  input  logic [MAP_BITS-1:0] map_idx,
  input  logic [RW-1:0]       row_idx,
  output logic [COLS-1:0]     row_pat
);

  // The ROM is stored at package geometry; narrower or wider rows are truncated/zero-padded.
  assign row_pat = COLS'(rom_row(int'(map_idx), int'(row_idx)));

endmodule

// File: rtl/led_matrix_scan.sv
// Row-scanning driver for an active-low LED matrix with blanking and frame-aligned map swaps.
// Pins are registered: they reflect the (row, prescaler) state one cycle earlier.
// No backpressure: loads are accepted every cycle; invalid indices pulse sel_err.
module led_matrix_scan
  import led_map_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int MAP_BITS = DEF_MAP_BITS,
  parameter int NUM_MAPS = DEF_NUM_MAPS,
  parameter int DIV      = 50000,
  parameter int BLANK    = 500
) (
  input logic               clk,
  input logic               rst,
  led_matrix_scan_if.slave  bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK);
  localparam logic [RW-1:0] R_LAST  = RW'(ROWS - 1);

  logic [PW-1:0]       p_q, p_d;
  logic [RW-1:0]       r_q, r_d;
  logic [MAP_BITS-1:0] pending_q, pending_d;
  logic                pend_q, pend_d;
  logic [MAP_BITS-1:0] active_q, active_d;
  logic [ROWS-1:0]     row_n_q, row_n_d;
  logic [COLS-1:0]     col_n_q, col_n_d;
  logic                frame_done_q, frame_done_d;
  logic                sel_err_q, sel_err_d;

  logic                slot_end;
  logic                frame_end;
  logic                sel_ok;
  logic [COLS-1:0]     rom_pat;

  assign slot_end  = bus.en && (p_q == P_LAST);
  assign frame_end = slot_end && (r_q == R_LAST);
  assign sel_ok    = int'(bus.map_sel) < NUM_MAPS;

  map_rom #(
    .COLS     (COLS),
    .MAP_BITS (MAP_BITS),
    .RW       (RW)
  ) u_map_rom (
    .map_idx (active_q),
    .row_idx (r_q),
    .row_pat (rom_pat)
  );

  // Prescaler and row counter; both freeze while the display is disabled.
  always_comb begin
    p_d = p_q;
    r_d = r_q;
    if (bus.en) begin
      if (slot_end) begin
        p_d = '0;
        r_d = (r_q == R_LAST) ? '0 : r_q + RW'(1);
      end else begin
        p_d = p_q + PW'(1);
      end
    end
  end

  // Map selection: immediate while disabled, otherwise parked until the frame boundary.
  // A load landing on the boundary itself bypasses the pending slot.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    if (bus.load && sel_ok && !bus.en) begin
      active_d = bus.map_sel;
      pend_d   = 1'b0;
    end else if (frame_end) begin
      if (bus.load && sel_ok) begin
        active_d = bus.map_sel;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        active_d = pending_q;
        pend_d   = 1'b0;
      end
    end else if (bus.load && sel_ok) begin
      pending_d = bus.map_sel;
      pend_d    = 1'b1;
    end
  end

  // Next pin values: rows stay dark during the blanking window to hide column switching.
  always_comb begin
    row_n_d      = '1;
    col_n_d      = '1;
    frame_done_d = frame_end;
    sel_err_d    = bus.load && !sel_ok;
    if (bus.en) begin
      col_n_d = ~rom_pat;
      if (p_q >= P_BLANK) begin
        row_n_d = ~(ROWS'(1) << r_q);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q          <= '0;
      r_q          <= '0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
      active_q     <= '0;
      row_n_q      <= '1;
      col_n_q      <= '1;
      frame_done_q <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      p_q          <= p_d;
      r_q          <= r_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      active_q     <= active_d;
      row_n_q      <= row_n_d;
      col_n_q      <= col_n_d;
      frame_done_q <= frame_done_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign bus.row_n      = row_n_q;
  assign bus.col_n      = col_n_q;
  assign bus.active_map = active_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sel_err    = sel_err_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with a fast prescaler (DIV=4, BLANK=1).
// Instance a has all 8 maps; instance b has NUM_MAPS=6 to exercise rejected loads.
module tb_led_matrix_scan;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  led_matrix_scan_if #(.ROWS(7), .COLS(5), .MAP_BITS(3)) ifa ();
  led_matrix_scan_if #(.ROWS(7), .COLS(5), .MAP_BITS(3)) ifb ();

  led_matrix_scan #(
    .ROWS(7), .COLS(5), .MAP_BITS(3), .NUM_MAPS(8), .DIV(4), .BLANK(1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  led_matrix_scan #(
    .ROWS(7), .COLS(5), .MAP_BITS(3), .NUM_MAPS(6), .DIV(4), .BLANK(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1ns past the edge; cyc counts edges since reset release.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    rst         = 1'b1;
    ifa.en      = 1'b1;
    ifa.load    = 1'b0;
    ifa.map_sel = '0;
    ifb.en      = 1'b1;
    ifb.load    = 1'b0;
    ifb.map_sel = '0;

    @(posedge clk);
    #1;
    check("rst_row_n",      32'(ifa.row_n),      32'h7F);
    check("rst_col_n",      32'(ifa.col_n),      32'h1F);
    check("rst_active",     32'(ifa.active_map), 32'h0);
    check("rst_frame_done", 32'(ifa.frame_done), 32'h0);
    check("rst_sel_err",    32'(ifa.sel_err),    32'h0);
    #6;
    rst = 1'b0;
    cyc = 0;

    // First row slot: blank cycle, then row 0 lit with map 0 row 0.
    tick();
    check("c1_row_n_blank", 32'(ifa.row_n), 32'h7F);
    check("c1_col_n_m0r0",  32'(ifa.col_n), 32'b10001);
    tick();
    check("c2_row0_on", 32'(ifa.row_n), 32'b1111110);
    run_to(4);
    check("c4_row0_on", 32'(ifa.row_n), 32'b1111110);
    ifb.load    = 1'b1;
    ifb.map_sel = 3'd2;
    tick();
    ifb.load = 1'b0;
    check("c5_row_n_blank", 32'(ifa.row_n), 32'h7F);
    check("c5_col_n_m0r1",  32'(ifa.col_n), 32'b01110);
    tick();
    check("c6_row1_on",    32'(ifa.row_n),   32'b1111101);
    check("c6_b_sel_err0", 32'(ifb.sel_err), 32'h0);

    // Deferred load on a, rejected load on b.
    run_to(10);
    ifa.load    = 1'b1;
    ifa.map_sel = 3'd5;
    ifb.load    = 1'b1;
    ifb.map_sel = 3'd7;
    tick();
    ifa.load = 1'b0;
    ifb.load = 1'b0;
    check("c11_a_active_hold", 32'(ifa.active_map), 32'h0);
    check("c11_b_sel_err",     32'(ifb.sel_err),    32'h1);
    check("c11_b_active_hold", 32'(ifb.active_map), 32'h0);
    tick();
    check("c12_b_sel_err_clr", 32'(ifb.sel_err), 32'h0);

    run_to(27);
    check("c27_a_active_old", 32'(ifa.active_map), 32'h0);
    check("c27_a_no_frame",   32'(ifa.frame_done), 32'h0);
    tick();
    check("c28_a_active_new", 32'(ifa.active_map), 32'h5);
    check("c28_a_frame_done", 32'(ifa.frame_done), 32'h1);
    check("c28_b_active",     32'(ifb.active_map), 32'h2);
    check("c28_b_frame_done", 32'(ifb.frame_done), 32'h1);
    tick();
    check("c29_frame_clr",  32'(ifa.frame_done), 32'h0);
    check("c29_col_n_m5r0", 32'(ifa.col_n),      32'b00000);
    check("c29_row_n",      32'(ifa.row_n),      32'h7F);

    // Two loads in one frame: only the second is shown.
    run_to(33);
    ifa.load    = 1'b1;
    ifa.map_sel = 3'd3;
    tick();
    ifa.load = 1'b0;
    check("c34_row1_on",    32'(ifa.row_n), 32'b1111101);
    check("c34_col_n_m5r1", 32'(ifa.col_n), 32'b01111);
    run_to(37);
    ifa.load    = 1'b1;
    ifa.map_sel = 3'd6;
    tick();
    ifa.load = 1'b0;
    run_to(40);
    check("c40_active_hold", 32'(ifa.active_map), 32'h5);
    run_to(55);
    check("c55_active_hold", 32'(ifa.active_map), 32'h5);
    tick();
    check("c56_active_last", 32'(ifa.active_map), 32'h6);
    check("c56_frame_done",  32'(ifa.frame_done), 32'h1);
    tick();
    check("c57_col_n_m6r0", 32'(ifa.col_n), 32'b11001);

    // Load on the boundary cycle itself takes effect at once.
    run_to(83);
    check("c83_active", 32'(ifa.active_map), 32'h6);
    ifa.load    = 1'b1;
    ifa.map_sel = 3'd2;
    tick();
    ifa.load = 1'b0;
    check("c84_active_direct", 32'(ifa.active_map), 32'h2);
    check("c84_frame_done",    32'(ifa.frame_done), 32'h1);
    tick();
    check("c85_col_n_m2r0", 32'(ifa.col_n),      32'b10001);
    check("c85_frame_clr",  32'(ifa.frame_done), 32'h0);

    // Disable at row 3, load while disabled, resume without restart.
    run_to(97);
    ifa.en = 1'b0;
    tick();
    check("c98_dis_row_n", 32'(ifa.row_n), 32'h7F);
    check("c98_dis_col_n", 32'(ifa.col_n), 32'h1F);
    ifa.load    = 1'b1;
    ifa.map_sel = 3'd4;
    tick();
    ifa.load = 1'b0;
    check("c99_dis_active", 32'(ifa.active_map), 32'h4);
    check("c99_dis_row_n",  32'(ifa.row_n),      32'h7F);
    check("c99_dis_col_n",  32'(ifa.col_n),      32'h1F);
    run_to(102);
    check("c102_dis_no_frame", 32'(ifa.frame_done), 32'h0);
    ifa.en = 1'b1;
    tick();
    check("c103_resume_row3",   32'(ifa.row_n), 32'b1110111);
    check("c103_resume_col_n",  32'(ifa.col_n), 32'b01101);
    run_to(106);
    check("c106_row4_blank",    32'(ifa.row_n), 32'h7F);
    check("c106_col_n_m4r4",    32'(ifa.col_n), 32'b00000);
    tick();
    check("c107_row4_on",       32'(ifa.row_n), 32'b1101111);

    // Asynchronous reset mid-row: pins go dark before the next edge.
    #3;
    rst = 1'b1;
    #1;
    check("arst_a_row_n",  32'(ifa.row_n),      32'h7F);
    check("arst_a_col_n",  32'(ifa.col_n),      32'h1F);
    check("arst_a_active", 32'(ifa.active_map), 32'h0);
    check("arst_b_row_n",  32'(ifb.row_n),      32'h7F);
    check("arst_b_active", 32'(ifb.active_map), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
